// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-back port arbiter.
package wb_port_arbiter_pkg;

    // Grant / data-mux select encodings.
    localparam logic SEL_REQ0 = 1'b0;
    localparam logic SEL_REQ1 = 1'b1;

    // Default widths used by the arbiter top.
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/wb_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, and a tie goes to the
// side that did not win last time.
module rr_pick2
    import wb_port_arbiter_pkg::*;
(
    input  logic V0,
    input  logic V1,
    input  logic LastGrant,
    output logic Winner,
    output logic Any
);

    // Pure combinational pick; with nobody requesting the winner parks on Req0.
    always_comb begin
        Any    = V0 | V1;
        Winner = SEL_REQ0;
        if (V0 && V1) begin
            Winner = ~LastGrant;
        end else if (V1) begin
            Winner = SEL_REQ1;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the ALU result (Req0)
// and load data (Req1) using round-robin arbitration and a one-entry
// registered output slot.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              Req0Valid,
    output logic              Req0Ready,
    input  logic [ADDR_W-1:0] Req0Addr,
    input  logic [DATA_W-1:0] Req0Data,
    input  logic              Req1Valid,
    output logic              Req1Ready,
    input  logic [ADDR_W-1:0] Req1Addr,
    input  logic [DATA_W-1:0] Req1Data,
    input  logic              WbStall,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              MuxSel,
    output logic [CNT_W-1:0]  Conflicts
);

    logic              r_regWrite;
    logic [ADDR_W-1:0] r_writeReg;
    logic [DATA_W-1:0] r_writeData;
    logic              r_muxSel;
    logic              r_lastGrant;
    logic [CNT_W-1:0]  r_conflicts;

    logic              w_winner;
    logic              w_any;
    logic              w_slotFree;
    logic              w_transfer;
    logic              w_bothValid;
    logic [ADDR_W-1:0] w_winAddr;
    logic [DATA_W-1:0] w_winData;

    rr_pick2 u_pick (
        .V0        (Req0Valid),
        .V1        (Req1Valid),
        .LastGrant (r_lastGrant),
        .Winner    (w_winner),
        .Any       (w_any)
    );

    // The slot can take a new entry when it is empty or is being drained this
    // cycle; a stall only matters when something is sitting in the slot.
    assign w_slotFree  = ~r_regWrite | ~WbStall;
    assign w_transfer  = RST_n & w_slotFree & w_any;
    assign w_bothValid = Req0Valid & Req1Valid;

    // Readies follow the arbitration decision only, and are forced low in reset.
    assign Req0Ready = RST_n & w_slotFree & (w_winner == SEL_REQ0);
    assign Req1Ready = RST_n & w_slotFree & (w_winner == SEL_REQ1);

    // Write-back data mux driven by the current winner.
    assign w_winAddr = (w_winner == SEL_REQ1) ? Req1Addr : Req0Addr;
    assign w_winData = (w_winner == SEL_REQ1) ? Req1Data : Req0Data;

    // Output slot, grant history and saturating conflict counter.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_regWrite  <= 1'b0;
            r_writeReg  <= '0;
            r_writeData <= '0;
            r_muxSel    <= SEL_REQ0;
            r_lastGrant <= SEL_REQ1;
            r_conflicts <= '0;
        end else if (w_transfer) begin
            r_regWrite  <= (w_winAddr != '0);
            r_writeReg  <= w_winAddr;
            r_writeData <= w_winData;
            r_muxSel    <= w_winner;
            r_lastGrant <= w_winner;
            if (w_bothValid && (r_conflicts != '1)) begin
                r_conflicts <= r_conflicts + CNT_W'(1);
            end
        end else if (w_slotFree) begin
            r_regWrite <= 1'b0;
        end
    end

    assign RegWrite  = r_regWrite;
    assign WriteReg  = r_writeReg;
    assign WriteData = r_writeData;
    assign MuxSel    = r_muxSel;
    assign Conflicts = r_conflicts;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for the write-back port arbiter.
module tb_wb_port_arbiter;

    logic        CLK;
    logic        RST_n;
    logic        Req0Valid;
    logic        Req0Ready;
    logic [4:0]  Req0Addr;
    logic [31:0] Req0Data;
    logic        Req1Valid;
    logic        Req1Ready;
    logic [4:0]  Req1Addr;
    logic [31:0] Req1Data;
    logic        WbStall;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        MuxSel;
    logic [15:0] Conflicts;

    logic        satReq0Ready;
    logic        satReq1Ready;
    logic        satRegWrite;
    logic [4:0]  satWriteReg;
    logic [31:0] satWriteData;
    logic        satMuxSel;
    logic [1:0]  satConflicts;

    int nTests;
    int nFailed;

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .Req0Valid (Req0Valid),
        .Req0Ready (Req0Ready),
        .Req0Addr  (Req0Addr),
        .Req0Data  (Req0Data),
        .Req1Valid (Req1Valid),
        .Req1Ready (Req1Ready),
        .Req1Addr  (Req1Addr),
        .Req1Data  (Req1Data),
        .WbStall   (WbStall),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .MuxSel    (MuxSel),
        .Conflicts (Conflicts)
    );

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dutSat (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .Req0Valid (Req0Valid),
        .Req0Ready (satReq0Ready),
        .Req0Addr  (Req0Addr),
        .Req0Data  (Req0Data),
        .Req1Valid (Req1Valid),
        .Req1Ready (satReq1Ready),
        .Req1Addr  (Req1Addr),
        .Req1Data  (Req1Data),
        .WbStall   (WbStall),
        .RegWrite  (satRegWrite),
        .WriteReg  (satWriteReg),
        .WriteData (satWriteData),
        .MuxSel    (satMuxSel),
        .Conflicts (satConflicts)
    );

    // Free-running 10-time-unit clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clearInputs();
        Req0Valid = 1'b0;
        Req0Addr  = '0;
        Req0Data  = '0;
        Req1Valid = 1'b0;
        Req1Addr  = '0;
        Req1Data  = '0;
        WbStall   = 1'b0;
    endtask

    task automatic doReset();
        clearInputs();
        RST_n = 1'b0;
        cycle();
        cycle();
        RST_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        doReset();
        Req0Valid = 1'b1;
        Req0Addr  = 5'd3;
        Req0Data  = 32'h0000_0055;
        cycle();
        nTests++;
        if (RegWrite !== 1'b1) begin
            nFailed++;
            $display("[TB] FAIL reset_preload RegWrite got %b expected 1", RegWrite);
        end
        Req0Valid = 1'b1;
        Req1Valid = 1'b1;
        Req1Addr  = 5'd4;
        #2;
        RST_n = 1'b0;
        #1;
        nTests++;
        if ({RegWrite, WriteReg, WriteData, MuxSel, Conflicts} !== '0) begin
            nFailed++;
            $display("[TB] FAIL reset_async outputs got rw=%b wr=%0d wd=%h sel=%b cnt=%0d expected all 0",
                     RegWrite, WriteReg, WriteData, MuxSel, Conflicts);
        end
        nTests++;
        if ({Req0Ready, Req1Ready} !== 2'b00) begin
            nFailed++;
            $display("[TB] FAIL reset_ready got %b%b expected 00", Req0Ready, Req1Ready);
        end
        @(negedge CLK);
        RST_n = 1'b1;
        #1;
        nTests++;
        if ({Req0Ready, Req1Ready} !== 2'b10) begin
            nFailed++;
            $display("[TB] FAIL reset_first_tie readies got %b%b expected 10", Req0Ready, Req1Ready);
        end
        cycle();
        nTests++;
        if (MuxSel !== 1'b0 || WriteReg !== 5'd3) begin
            nFailed++;
            $display("[TB] FAIL reset_first_grant sel=%b wr=%0d expected sel=0 wr=3", MuxSel, WriteReg);
        end
    endtask

    task automatic test_single();
        doReset();
        Req0Valid = 1'b1;
        Req0Addr  = 5'd5;
        Req0Data  = 32'hDEADBEEF;
        #1;
        nTests++;
        if ({Req0Ready, Req1Ready} !== 2'b10) begin
            nFailed++;
            $display("[TB] FAIL single_ready got %b%b expected 10", Req0Ready, Req1Ready);
        end
        cycle();
        clearInputs();
        nTests++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd5 || WriteData !== 32'hDEADBEEF || MuxSel !== 1'b0) begin
            nFailed++;
            $display("[TB] FAIL single_out got rw=%b wr=%0d wd=%h sel=%b expected 1 5 deadbeef 0",
                     RegWrite, WriteReg, WriteData, MuxSel);
        end
        cycle();
        nTests++;
        if (RegWrite !== 1'b0 || WriteReg !== 5'd5 || WriteData !== 32'hDEADBEEF) begin
            nFailed++;
            $display("[TB] FAIL single_idle got rw=%b wr=%0d wd=%h expected 0 5 deadbeef",
                     RegWrite, WriteReg, WriteData);
        end
    endtask

    task automatic test_round_robin();
        logic        expSel;
        logic [4:0]  expReg;
        logic [31:0] expData;
        doReset();
        Req0Valid = 1'b1;
        Req0Addr  = 5'd1;
        Req0Data  = 32'h0000_00A0;
        Req1Valid = 1'b1;
        Req1Addr  = 5'd2;
        Req1Data  = 32'h0000_00B1;
        for (int k = 0; k < 4; k++) begin
            expSel  = k[0];
            expReg  = expSel ? 5'd2 : 5'd1;
            expData = expSel ? 32'h0000_00B1 : 32'h0000_00A0;
            #1;
            nTests++;
            if ({Req0Ready, Req1Ready} !== {~expSel, expSel}) begin
                nFailed++;
                $display("[TB] FAIL rr_ready[%0d] got %b%b expected %b%b", k, Req0Ready, Req1Ready, ~expSel, expSel);
            end
            cycle();
            nTests++;
            if (MuxSel !== expSel || WriteReg !== expReg || WriteData !== expData || RegWrite !== 1'b1) begin
                nFailed++;
                $display("[TB] FAIL rr_grant[%0d] got sel=%b wr=%0d wd=%h rw=%b expected sel=%b wr=%0d wd=%h rw=1",
                         k, MuxSel, WriteReg, WriteData, RegWrite, expSel, expReg, expData);
            end
        end
        nTests++;
        if (Conflicts !== 16'd4) begin
            nFailed++;
            $display("[TB] FAIL rr_conflicts got %0d expected 4", Conflicts);
        end
        clearInputs();
    endtask

    task automatic test_stall();
        doReset();
        WbStall   = 1'b1;
        Req0Valid = 1'b1;
        Req0Addr  = 5'd7;
        Req0Data  = 32'h0000_0077;
        #1;
        nTests++;
        if (Req0Ready !== 1'b1) begin
            nFailed++;
            $display("[TB] FAIL stall_empty_accept Req0Ready got %b expected 1", Req0Ready);
        end
        cycle();
        Req0Valid = 1'b0;
        Req1Valid = 1'b1;
        Req1Addr  = 5'd9;
        Req1Data  = 32'h0000_0099;
        for (int k = 0; k < 3; k++) begin
            #1;
            nTests++;
            if ({Req0Ready, Req1Ready} !== 2'b00) begin
                nFailed++;
                $display("[TB] FAIL stall_ready[%0d] got %b%b expected 00", k, Req0Ready, Req1Ready);
            end
            cycle();
            nTests++;
            if (RegWrite !== 1'b1 || WriteReg !== 5'd7 || WriteData !== 32'h0000_0077 || MuxSel !== 1'b0) begin
                nFailed++;
                $display("[TB] FAIL stall_hold[%0d] got rw=%b wr=%0d wd=%h sel=%b expected 1 7 77 0",
                         k, RegWrite, WriteReg, WriteData, MuxSel);
            end
        end
        WbStall = 1'b0;
        #1;
        nTests++;
        if ({Req0Ready, Req1Ready} !== 2'b01) begin
            nFailed++;
            $display("[TB] FAIL stall_release_ready got %b%b expected 01", Req0Ready, Req1Ready);
        end
        cycle();
        nTests++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd9 || WriteData !== 32'h0000_0099 || MuxSel !== 1'b1) begin
            nFailed++;
            $display("[TB] FAIL stall_release_load got rw=%b wr=%0d wd=%h sel=%b expected 1 9 99 1",
                     RegWrite, WriteReg, WriteData, MuxSel);
        end
        clearInputs();
    endtask

    task automatic test_x0();
        doReset();
        Req1Valid = 1'b1;
        Req1Addr  = 5'd0;
        Req1Data  = 32'h0000_0123;
        #1;
        nTests++;
        if ({Req0Ready, Req1Ready} !== 2'b01) begin
            nFailed++;
            $display("[TB] FAIL x0_ready got %b%b expected 01", Req0Ready, Req1Ready);
        end
        cycle();
        clearInputs();
        nTests++;
        if (RegWrite !== 1'b0 || MuxSel !== 1'b1 || WriteReg !== 5'd0) begin
            nFailed++;
            $display("[TB] FAIL x0_out got rw=%b sel=%b wr=%0d expected 0 1 0", RegWrite, MuxSel, WriteReg);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] expSat;
        doReset();
        Req0Valid = 1'b1;
        Req0Addr  = 5'd1;
        Req0Data  = 32'h1;
        Req1Valid = 1'b1;
        Req1Addr  = 5'd2;
        Req1Data  = 32'h2;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            expSat = (k >= 3) ? 2'd3 : 2'(k);
            nTests++;
            if (satConflicts !== expSat) begin
                nFailed++;
                $display("[TB] FAIL sat_count[%0d] got %0d expected %0d", k, satConflicts, expSat);
            end
        end
        nTests++;
        if (Conflicts !== 16'd5) begin
            nFailed++;
            $display("[TB] FAIL sat_wide_count got %0d expected 5", Conflicts);
        end
        clearInputs();
    endtask

    // Runs every scenario in order, then reports the totals.
    initial begin
        nTests  = 0;
        nFailed = 0;
        clearInputs();
        RST_n = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_x0();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", nTests, nFailed);
        $finish;
    end

endmodule
